// File: rtl/traffic_ctrl_param.sv
// Two-road traffic light controller: G1/Y1/R1/G2/Y2/R2 cycle timed by an external tick strobe,
// night flashing mode, optional pedestrian green-shortening when `PED_REQ_EN is defined.
//
// state | meaning
// G1    | road-1 green, road-2 red
// Y1    | road-1 yellow, road-2 red
// R1    | all-red clearance before road-2 green
// G2    | road-2 green, road-1 red
// Y2    | road-2 yellow, road-1 red
// R2    | all-red clearance before road-1 green (also reset / night exit)
// NIGHT | both heads flash yellow together
module traffic_ctrl_param #(
   parameter int CNT_W     = 6,
   parameter int GREEN1_T  = 25,
   parameter int GREEN2_T  = 25,
   parameter int YELLOW_T  = 5,
   parameter int ALL_RED_T = 2,
   parameter int PED_MIN_T = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             night,
`ifdef PED_REQ_EN
   input  logic [1:0]       ped_req,
`endif
   output logic [2:0]       light1,
   output logic [2:0]       light2,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [2:0] {G1, Y1, R1, G2, Y2, R2, NIGHT} state_t;

   localparam logic [CNT_W-1:0] G1_LD  = CNT_W'(GREEN1_T - 1);
   localparam logic [CNT_W-1:0] G2_LD  = CNT_W'(GREEN2_T - 1);
   localparam logic [CNT_W-1:0] Y_LD   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] AR_LD  = CNT_W'(ALL_RED_T - 1);
   localparam logic [2:0]       H_GRN  = 3'b100;
   localparam logic [2:0]       H_RED  = 3'b010;
   localparam logic [2:0]       H_YEL  = 3'b001;

   if (GREEN1_T < 1 || GREEN2_T < 1 || YELLOW_T < 1 || ALL_RED_T < 1 ||
       PED_MIN_T < 1 || PED_MIN_T > GREEN1_T || PED_MIN_T > GREEN2_T) begin : g_bad_param
      $error("traffic_ctrl_param: illegal phase length parameter");
   end

   state_t state;

   function automatic state_t succ(input state_t s);
      case (s)
         G1:      return Y1;
         Y1:      return R1;
         R1:      return G2;
         G2:      return Y2;
         Y2:      return R2;
         default: return G1;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] load_of(input state_t s);
      case (s)
         G1:      return G1_LD;
         G2:      return G2_LD;
         Y1, Y2:  return Y_LD;
         default: return AR_LD;
      endcase
   endfunction

   function automatic logic [5:0] heads_of(input state_t s);
      case (s)
         G1:      return {H_GRN, H_RED};
         Y1:      return {H_YEL, H_RED};
         G2:      return {H_RED, H_GRN};
         Y2:      return {H_RED, H_YEL};
         default: return {H_RED, H_RED};
      endcase
   endfunction

`ifdef PED_REQ_EN
   localparam logic [CNT_W-1:0] PED_LD = CNT_W'(PED_MIN_T - 1);
   logic [1:0] ped_lat;
   logic [1:0] ped_eff;
   logic [1:0] ped_clr;
   logic       ped_hit;

   // a request arriving on the tick edge itself still counts for that tick
   assign ped_eff = ped_lat | ped_req;
   assign ped_clr = {state == G2, state == G1};
   assign ped_hit = |(ped_eff & ped_clr);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= R2;
         count  <= AR_LD;
         light1 <= H_RED;
         light2 <= H_RED;
`ifdef PED_REQ_EN
         ped_lat <= 2'b00;
`endif
      end else begin
`ifdef PED_REQ_EN
         ped_lat <= ped_eff;
`endif
         if (tick) begin
            if (night) begin
               if (state != NIGHT) begin
                  state  <= NIGHT;
                  count  <= '0;
                  light1 <= H_YEL;
                  light2 <= H_YEL;
               end else begin
                  light1 <= light1 ^ H_YEL;
                  light2 <= light2 ^ H_YEL;
               end
`ifdef PED_REQ_EN
               ped_lat <= 2'b00;
`endif
            end else if (state == NIGHT) begin
               state  <= R2;
               count  <= AR_LD;
               light1 <= H_RED;
               light2 <= H_RED;
            end else begin
               if (count == '0) begin
                  state            <= succ(state);
                  count            <= load_of(succ(state));
                  {light1, light2} <= heads_of(succ(state));
`ifdef PED_REQ_EN
               end else if (ped_hit && count > PED_LD) begin
                  count <= PED_LD;
`endif
               end else begin
                  count <= count - 1'b1;
               end
`ifdef PED_REQ_EN
               ped_lat <= ped_eff & ~ped_clr;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Randomised self-checking bench for traffic_ctrl_param against a phase-table reference model.
module tb_traffic_ctrl_param;
   localparam int CNT_W = 6;
   localparam int PED_MIN = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tick = 1'b0;
   logic             night = 1'b0;
   logic [1:0]       ped_req = 2'b00;
   logic [2:0]       light1, light2;
   logic [CNT_W-1:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   traffic_ctrl_param dut (
      .clk(clk), .rst(rst), .tick(tick), .night(night),
`ifdef PED_REQ_EN
      .ped_req(ped_req),
`endif
      .light1(light1), .light2(light2), .count(count)
   );

   // phase 0..5 = G1,Y1,R1,G2,Y2,R2 ; 6 = night
   int         len_t [6] = '{25, 5, 2, 25, 5, 2};
   logic [2:0] h1    [6] = '{3'b100, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010};
   logic [2:0] h2    [6] = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
   int         m_ph, m_cnt;
   bit         m_flash;
   bit [1:0]   m_ped;

   function automatic logic [2:0] exp_l1();
      return (m_ph == 6) ? (m_flash ? 3'b001 : 3'b000) : h1[m_ph];
   endfunction
   function automatic logic [2:0] exp_l2();
      return (m_ph == 6) ? (m_flash ? 3'b001 : 3'b000) : h2[m_ph];
   endfunction

   task automatic model_reset();
      m_ph = 5; m_cnt = len_t[5] - 1; m_flash = 0; m_ped = 0;
   endtask

   task automatic model_tick(input bit n);
      int old;
      bit hit;
      if (n) begin
         if (m_ph != 6) begin m_ph = 6; m_cnt = 0; m_flash = 1; end
         else m_flash = !m_flash;
         m_ped = 0;
      end else if (m_ph == 6) begin
         m_ph = 5; m_cnt = len_t[5] - 1;
      end else begin
         old = m_ph;
`ifdef PED_REQ_EN
         hit = (old == 0 && m_ped[0]) || (old == 3 && m_ped[1]);
`else
         hit = 0;
`endif
         if (m_cnt == 0) begin m_ph = (m_ph + 1) % 6; m_cnt = len_t[m_ph] - 1; end
         else if (hit && m_cnt > PED_MIN - 1) m_cnt = PED_MIN - 1;
         else m_cnt = m_cnt - 1;
         if (old == 0) m_ped[0] = 0;
         if (old == 3) m_ped[1] = 0;
      end
   endtask

   // one clock with the given inputs; the model advances only when tick is set
   task automatic cyc(input bit t, input bit n, input bit [1:0] p);
      tick = t; night = n; ped_req = p;
      @(posedge clk);
      #1;
`ifdef PED_REQ_EN
      m_ped = m_ped | p;
`endif
      if (t) model_tick(n);
      tick = 0; ped_req = 2'b00;
   endtask

   task automatic run_until(input int ph, input int cnt, output bit ok);
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (m_ph == ph && m_cnt == cnt) ok = 1;
         else cyc(1, 0, 2'b00);
      end
   endtask

   task automatic test_reset();
      rst = 1; cyc(0, 0, 2'b00); cyc(0, 0, 2'b00);
      n_tests++;
      if ({light1, light2, count} !== {3'b010, 3'b010, 6'd1}) begin
         n_fail++; $display("FAIL reset_vals got %b %b %0d want 010 010 1", light1, light2, count);
      end
      rst = 0; model_reset();
      cyc(1, 0, 2'b00); cyc(0, 0, 2'b00); cyc(1, 0, 2'b00);
      n_tests++;
      if ({light1, light2, count} !== {3'b100, 3'b010, 6'd24}) begin
         n_fail++; $display("FAIL reset_to_g1 got %b %b %0d want 100 010 24", light1, light2, count);
      end
   endtask

   task automatic test_cycle();
      int  tick_no = 0, g1_tick = 0;
      bit  g1_seen = 0;
      logic [2:0] prev1;
      for (int t = 0; t < 200; t++) begin
         for (int c = 0; c < 4; c++) begin
            prev1 = light1;
            cyc(c == 3, 0, 2'b00);
            n_tests++;
            if ({light1, light2, count} !== {exp_l1(), exp_l2(), CNT_W'(m_cnt)}) begin
               n_fail++;
               $display("FAIL cycle t=%0d c=%0d got %b %b %0d want %b %b %0d",
                        t, c, light1, light2, count, exp_l1(), exp_l2(), m_cnt);
            end
         end
         tick_no++;
         if (prev1 != 3'b100 && light1 == 3'b100) begin
            if (g1_seen) begin
               n_tests++;
               if (tick_no - g1_tick != 64) begin
                  n_fail++; $display("FAIL cycle_len got %0d want 64", tick_no - g1_tick);
               end
            end
            g1_seen = 1; g1_tick = tick_no;
         end
         if (g1_seen && prev1 == 3'b100 && light1 == 3'b001) begin
            n_tests++;
            if (tick_no - g1_tick != 25) begin
               n_fail++; $display("FAIL y1_entry got %0d want 25", tick_no - g1_tick);
            end
         end
      end
   endtask

   task automatic test_night();
      bit ok;
      run_until(3, 10, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL night_reach got timeout want G2 count 10"); return; end
      cyc(1, 1, 2'b00);
      n_tests++;
      if ({light1, light2, count} !== {3'b001, 3'b001, 6'd0}) begin
         n_fail++; $display("FAIL night_entry got %b %b %0d want 001 001 0", light1, light2, count);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 2'b00);
         cyc(1, 1, 2'b00);
         n_tests++;
         if ({light1, light2} !== ((i % 2 == 0) ? 6'b000000 : 6'b001001)) begin
            n_fail++; $display("FAIL night_flash i=%0d got %b %b", i, light1, light2);
         end
      end
      cyc(1, 0, 2'b00);
      n_tests++;
      if ({light1, light2, count} !== {3'b010, 3'b010, 6'd1}) begin
         n_fail++; $display("FAIL night_exit got %b %b %0d want 010 010 1", light1, light2, count);
      end
      cyc(1, 0, 2'b00); cyc(1, 0, 2'b00);
      n_tests++;
      if ({light1, light2, count} !== {3'b100, 3'b010, 6'd24}) begin
         n_fail++; $display("FAIL night_to_g1 got %b %b %0d want 100 010 24", light1, light2, count);
      end
   endtask

   task automatic test_night_glitch();
      cyc(1, 0, 2'b00);
      cyc(0, 1, 2'b00); cyc(0, 1, 2'b00); cyc(0, 0, 2'b00);
      cyc(1, 0, 2'b00);
      n_tests++;
      if ({light1, light2, count} !== {exp_l1(), exp_l2(), CNT_W'(m_cnt)} || m_ph == 6) begin
         n_fail++;
         $display("FAIL night_glitch got %b %b %0d want %b %b %0d",
                  light1, light2, count, exp_l1(), exp_l2(), m_cnt);
      end
   endtask

   task automatic test_rst_midrun();
      for (int i = 0; i < 9; i++) cyc(1, 0, 2'b00);
      @(posedge clk); #3; rst = 1; #1;
      n_tests++;
      if ({light1, light2, count} !== {3'b010, 3'b010, 6'd1}) begin
         n_fail++; $display("FAIL rst_async got %b %b %0d want 010 010 1", light1, light2, count);
      end
      tick = 1; @(posedge clk); #1; tick = 0;
      n_tests++;
      if ({light1, light2, count} !== {3'b010, 3'b010, 6'd1}) begin
         n_fail++; $display("FAIL rst_hold got %b %b %0d want 010 010 1", light1, light2, count);
      end
      rst = 0; model_reset();
   endtask

   task automatic test_random();
      bit       nv = 0;
      bit [1:0] p;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) nv = !nv;
         p = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cyc($urandom_range(0, 2) == 0, nv, p);
         n_tests++;
         if ({light1, light2, count} !== {exp_l1(), exp_l2(), CNT_W'(m_cnt)}) begin
            n_fail++;
            $display("FAIL random i=%0d got %b %b %0d want %b %b %0d",
                     i, light1, light2, count, exp_l1(), exp_l2(), m_cnt);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1, 0, 2'b00);
   endtask

`ifdef PED_REQ_EN
   task automatic test_ped();
      bit ok;
      run_until(0, 20, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ped_reach got timeout want G1 20"); return; end
      cyc(0, 0, 2'b01); cyc(1, 0, 2'b00);
      n_tests++;
      if (count !== 6'd4) begin n_fail++; $display("FAIL ped_short got %0d want 4", count); end
      for (int i = 0; i < 5; i++) cyc(1, 0, 2'b00);
      n_tests++;
      if ({light1, count} !== {3'b001, 6'd4}) begin
         n_fail++; $display("FAIL ped_y1 got %b %0d want 001 4", light1, count);
      end
      run_until(0, 3, ok);
      cyc(0, 0, 2'b01); cyc(1, 0, 2'b00);
      n_tests++;
      if (!ok || count !== 6'd2) begin n_fail++; $display("FAIL ped_low got %0d want 2", count); end
      run_until(0, 15, ok);
      cyc(0, 0, 2'b10);
      run_until(3, 24, ok);
      n_tests++;
      if (!ok || {light2, count} !== {3'b100, 6'd24}) begin
         n_fail++; $display("FAIL ped_g2_entry got %b %0d want 100 24", light2, count);
      end
      cyc(1, 0, 2'b00);
      n_tests++;
      if (count !== 6'd4) begin n_fail++; $display("FAIL ped_g2_short got %0d want 4", count); end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_cycle();
      test_night();
      test_night_glitch();
      test_rst_midrun();
      test_random();
`ifdef PED_REQ_EN
      test_ped();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
